// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares the AR/R read channel of one AXI4 slave between NUM_M read masters.
// Only one burst is outstanding: the grant is taken in IDLE, the AR beat is
// forwarded in ADDR, and R beats are routed to the granted master in DATA
// until the RLAST handshake. Write channels do not pass through this block.
//
// Per-master signals are flat vectors; master i lives at [i*W +: W].
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axi_ar*  (per master)    AR requests from the masters
//   s_axi_arready[NUM_M]       AR ready back to the masters
//   s_axi_rid/rdata/rresp/rlast R payload, broadcast to every master
//   s_axi_rvalid[NUM_M]        R valid, only the granted master's bit
//   s_axi_rready[NUM_M]        R ready from the masters
//   m_axi_ar*                  AR channel to the slave
//   m_axi_r*                   R channel from the slave
//
// Build option:
//   AXI_RD_ARB_FIXED_PRIO_EN   when defined, the lowest-index requester always
//                              wins and no round-robin pointer exists.
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int NUM_M      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_M*ID_WIDTH-1:0]    s_axi_arid,
  input  logic [NUM_M*ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [NUM_M*8-1:0]           s_axi_arlen,
  input  logic [NUM_M*3-1:0]           s_axi_arsize,
  input  logic [NUM_M*2-1:0]           s_axi_arburst,
  input  logic [NUM_M-1:0]             s_axi_arvalid,
  output logic [NUM_M-1:0]             s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic [NUM_M-1:0]             s_axi_rvalid,
  input  logic [NUM_M-1:0]             s_axi_rready,
  output logic [ID_WIDTH-1:0]          m_axi_arid,
  output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  input  logic [ID_WIDTH-1:0]          m_axi_rid,
  input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   w_grant_nxt;
  logic [GW-1:0]   w_pick;

  // Signals of the currently granted master.
  logic [NUM_M-1:0]      w_gnt_oh;
  logic                  w_sel_arvalid;
  logic                  w_sel_rready;
  logic [ID_WIDTH-1:0]   w_sel_arid;
  logic [ADDR_WIDTH-1:0] w_sel_araddr;
  logic [7:0]            w_sel_arlen;
  logic [2:0]            w_sel_arsize;
  logic [1:0]            w_sel_arburst;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last one written.
  always_comb begin
    w_pick = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (s_axi_arvalid[i]) w_pick = GW'(i);
    end
  end
`else
  logic [GW-1:0]    r_rr_ptr;
  logic [GW-1:0]    w_rr_ptr_nxt;
  logic [NUM_M-1:0] w_req_rot;
  logic             w_found;

  // Rotate the request vector so bit 0 corresponds to rr_ptr, then take the
  // first set bit and map it back to an absolute master index.
  always_comb begin
    w_req_rot = NUM_M'({s_axi_arvalid, s_axi_arvalid} >> r_rr_ptr);
    w_pick    = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_pick  = GW'((int'(r_rr_ptr) + k) % NUM_M);
        w_found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_gnt_oh      = '0;
    w_sel_arvalid = 1'b0;
    w_sel_rready  = 1'b0;
    w_sel_arid    = '0;
    w_sel_araddr  = '0;
    w_sel_arlen   = '0;
    w_sel_arsize  = '0;
    w_sel_arburst = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant == GW'(i)) begin
        w_gnt_oh[i]   = 1'b1;
        w_sel_arvalid = s_axi_arvalid[i];
        w_sel_rready  = s_axi_rready[i];
        w_sel_arid    = s_axi_arid[i*ID_WIDTH +: ID_WIDTH];
        w_sel_araddr  = s_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_arlen   = s_axi_arlen[i*8 +: 8];
        w_sel_arsize  = s_axi_arsize[i*3 +: 3];
        w_sel_arburst = s_axi_arburst[i*2 +: 2];
      end
    end
  end

  // R payload is a pure wire path; only the valid/ready pair is steered.
  assign s_axi_rid   = m_axi_rid;
  assign s_axi_rdata = m_axi_rdata;
  assign s_axi_rresp = m_axi_rresp;
  assign s_axi_rlast = m_axi_rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
      r_rr_ptr <= w_rr_ptr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
    w_rr_ptr_nxt  = r_rr_ptr;
`endif
    m_axi_arid    = '0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = '0;
    m_axi_arburst = '0;
    m_axi_arvalid = 1'b0;
    s_axi_arready = '0;
    s_axi_rvalid  = '0;
    m_axi_rready  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|s_axi_arvalid) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_ADDR;
        end
      end

      ST_ADDR: begin
        // A granted master that drops arvalid keeps the grant; the request
        // simply stops being presented until it returns.
        m_axi_arid    = w_sel_arid;
        m_axi_araddr  = w_sel_araddr;
        m_axi_arlen   = w_sel_arlen;
        m_axi_arsize  = w_sel_arsize;
        m_axi_arburst = w_sel_arburst;
        m_axi_arvalid = w_sel_arvalid;
        s_axi_arready = w_gnt_oh & {NUM_M{m_axi_arready}};
        if (w_sel_arvalid && m_axi_arready) begin
          w_state_nxt = ST_DATA;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
          w_rr_ptr_nxt = (r_grant == GW'(NUM_M - 1)) ? '0 : r_grant + GW'(1);
`endif
        end
      end

      ST_DATA: begin
        m_axi_rready = w_sel_rready;
        s_axi_rvalid = w_gnt_oh & {NUM_M{m_axi_rvalid}};
        if (m_axi_rvalid && w_sel_rready && m_axi_rlast) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
